program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 23 ++
 rtl/program_loader_byte_assembler.sv | 36 +++
 rtl/program_loader.sv | 112 +++++++++++
 tb/tb_program_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared loader constants: FSM encoding, checksum width and the word address helper.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int CHK_W  = 8;
  localparam int BYTE_W = 8;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs bytes MSB-first into a 32-bit word and XOR-accumulates them; word_full flags the 4th byte
// combinationally. No flow control of its own: it shifts whenever shift_en is high.
module loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [31:0]       word,
  output logic              word_full,
  output logic [CHK_W-1:0]  chk_acc
);

  logic [1:0] byte_idx;

  assign word_full = shift_en && (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word     <= '0;
      byte_idx <= '0;
      chk_acc  <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_idx <= '0;
      chk_acc  <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], byte_in};
      byte_idx <= byte_idx + 2'd1;
      chk_acc  <= chk_acc ^ byte_in;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory; one write cycle
// after each 4th data byte. Backpressure: rx_ready drops outside LEN_HI/LEN_LO/DATA/CHK (incl. WRITE).
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t             state, state_nxt;
  logic [7:0]         len_hi;
  logic [15:0]        len;
  logic [15:0]        word_cnt;
  logic [15:0]        word_cnt_inc;
  logic [15:0]        len_in;
  logic               len_bad;
  logic               accept;
  logic               load_go;
  logic [31:0]        word;
  logic               word_full;
  logic [CHK_W-1:0]   chk_acc;

  assign rx_ready     = state inside {LEN_HI, LEN_LO, DATA, CHK};
  assign accept       = rx_valid && rx_ready;
  assign load_go      = start && (state inside {IDLE, DONE, ERR});
  assign len_in       = {len_hi, rx_data};
  assign len_bad      = (len_in == 16'd0) || ({1'b0, len_in} > MAX_N);
  assign word_cnt_inc = word_cnt + 16'd1;
  assign word_count   = word_cnt;

  loader_byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_go),
    .shift_en  (accept && (state == DATA)),
    .byte_in   (rx_data),
    .word      (word),
    .word_full (word_full),
    .chk_acc   (chk_acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi   <= '0;
      len      <= '0;
      word_cnt <= '0;
    end else begin
      if (load_go)             word_cnt <= '0;
      else if (state == WRITE) word_cnt <= word_cnt_inc;
      if (accept && state == LEN_HI) len_hi <= rx_data;
      if (accept && state == LEN_LO) len    <= len_in;
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_nxt = LEN_HI;
      end
      LEN_HI: if (accept) state_nxt = LEN_LO;
      LEN_LO: if (accept) state_nxt = len_bad ? ERR : DATA;
      DATA:   if (word_full) state_nxt = WRITE;
      WRITE: begin
        imem_we    = 1'b1;
        imem_addr  = word_addr(BASE_ADDR, word_cnt);
        imem_wdata = word;
        state_nxt  = (word_cnt_inc == len) ? CHK : DATA;
      end
      CHK:    if (accept) state_nxt = (rx_data == chk_acc) ? DONE : ERR;
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_nxt = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nxt = LEN_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad loads, length limits, gaps, restart and async reset.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int          MAXW = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, imem_we, cpu_hold, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;

  program_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]       byte_q[$];
  logic [31:0]      exp_q[$];
  logic [31:0]      wr_addr_q[$];
  logic [31:0]      wr_data_q[$];
  logic [CHK_W-1:0] chk;
  int               acc_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk)
    if (reset && rx_valid && rx_ready) acc_cnt++;

  always @(negedge clk)
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      check("rdy_in_write", {31'd0, rx_ready}, 32'd0);
    end

  task automatic new_stream();
    byte_q.delete(); exp_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    chk = '0;
    acc_cnt = 0;
  endtask

  task automatic push_len(input logic [15:0] n);
    byte_q.push_back(n[15:8]);
    byte_q.push_back(n[7:0]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      byte_q.push_back(w[8*i +: 8]);
      chk ^= w[8*i +: 8];
    end
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g, t;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    if (g > 0) begin
      @(negedge clk) rx_valid = 1'b0;
      repeat (g - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      check("rx_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input int lo, input int hi, input int gapmax);
    for (int i = lo; i < hi; i++) begin
      send_byte(byte_q[i], gapmax);
      if (i >= 2 && (i - 2) % 4 == 3 && (i - 2) / 4 < exp_q.size())
        check("we_latency", {31'd0, imem_we}, 32'd1);
    end
  endtask

  task automatic finish_stream();
    @(negedge clk) rx_valid = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_data_q.size(), exp_q.size());
    if (wr_data_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) begin
        check({tag, "_addr"}, wr_addr_q[i], BASE + 32'(4 * i));
        check({tag, "_data"}, wr_data_q[i], exp_q[i]);
      end
  endtask

  task automatic build_example(input logic [7:0] chk_byte, input bit use_model);
    new_stream();
    push_len(16'd2);
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    byte_q.push_back(use_model ? chk : chk_byte);
  endtask

  initial begin
    #23;
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_flags", {30'd0, done, error}, 32'd0);
    check("rst_wc", {16'd0, word_count}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    @(negedge clk) reset = 1'b1;

    // No start: a presented byte must not be taken.
    new_stream();
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (4) @(negedge clk);
    check("nostart_acc", acc_cnt, 32'd0);
    rx_valid = 1'b0;

    // Good load; XOR of these eight data bytes is 0x00.
    build_example(8'h00, 1'b1);
    check("ex_chk_model", {24'd0, chk}, 32'h00);
    start_pulse();
    send_range(0, byte_q.size(), 0);
    finish_stream();
    check("good_done", {30'd0, done, error}, 32'd2);
    check("good_hold", {31'd0, cpu_hold}, 32'd0);
    check("good_wc", {16'd0, word_count}, 32'd2);
    check_writes("good");

    // Bad checksum.
    build_example(8'h09, 1'b0);
    start_pulse();
    send_range(0, byte_q.size(), 0);
    finish_stream();
    check("bad_flags", {30'd0, done, error}, 32'd1);
    check("bad_hold", {31'd0, cpu_hold}, 32'd1);
    check("bad_wc", {16'd0, word_count}, 32'd2);
    check_writes("bad");

    // Restart from ERR, then N=0.
    new_stream();
    start_pulse();
    check("err_restart_wc", {16'd0, word_count}, 32'd0);
    check("err_restart_flags", {29'd0, cpu_hold, done, error}, 32'd4);
    push_len(16'd0);
    send_range(0, 2, 0);
    check("n0_err", {31'd0, error}, 32'd1);
    finish_stream();
    repeat (2) @(negedge clk);
    check("n0_nwr", wr_data_q.size(), 32'd0);

    // N = MAX_WORDS + 1.
    new_stream();
    push_len(16'(MAXW + 1));
    start_pulse();
    send_range(0, 2, 0);
    check("nmax1_err", {31'd0, error}, 32'd1);
    finish_stream();
    check("nmax1_nwr", wr_data_q.size(), 32'd0);

    // N = MAX_WORDS with random gaps and held-high valid.
    new_stream();
    push_len(16'(MAXW));
    for (int i = 0; i < MAXW; i++)
      push_word({8'(i), 8'hA5, 8'(3 * i + 1), 8'h5C});
    byte_q.push_back(chk);
    start_pulse();
    send_range(0, byte_q.size(), 3);
    finish_stream();
    check("max_done", {31'd0, done}, 32'd1);
    check("max_wc", {16'd0, word_count}, 32'(MAXW));
    check("max_bytes", acc_cnt, byte_q.size());
    check_writes("max");
    if (wr_addr_q.size() > 0)
      check("max_last_addr", wr_addr_q[wr_addr_q.size() - 1], BASE + 32'(4 * (MAXW - 1)));

    // Restart from DONE, with a start pulse mid-DATA that must be ignored.
    build_example(8'h00, 1'b1);
    start_pulse();
    check("done_restart_wc", {16'd0, word_count}, 32'd0);
    check("done_restart_done", {31'd0, done}, 32'd0);
    send_range(0, 5, 0);
    start_pulse();
    send_range(5, byte_q.size(), 0);
    finish_stream();
    check("middata_start_done", {31'd0, done}, 32'd1);
    check("middata_start_wc", {16'd0, word_count}, 32'd2);
    check_writes("middata");

    // Async reset after 5 data bytes.
    build_example(8'h00, 1'b1);
    start_pulse();
    send_range(0, 7, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_hold", {31'd0, cpu_hold}, 32'd0);
    check("midrst_ready", {31'd0, rx_ready}, 32'd0);
    check("midrst_wc", {16'd0, word_count}, 32'd0);
    check("midrst_we_flags", {29'd0, imem_we, done, error}, 32'd0);
    rx_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    build_example(8'h00, 1'b1);
    start_pulse();
    send_range(0, byte_q.size(), 1);
    finish_stream();
    check("postrst_done", {31'd0, done}, 32'd1);
    check_writes("postrst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
